// File: rtl/apb_regs_pkg.sv
// Shared types and constants for the APB register-bank completer.
package apb_regs_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned WCNT_W      = 4;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned NUM_RW_REGS = 6;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic [4:0] OFF_REG0   = 5'h00;
  localparam logic [4:0] OFF_REG1   = 5'h04;
  localparam logic [4:0] OFF_REG2   = 5'h08;
  localparam logic [4:0] OFF_REG3   = 5'h0C;
  localparam logic [4:0] OFF_REG4   = 5'h10;
  localparam logic [4:0] OFF_REG5   = 5'h14;
  localparam logic [4:0] OFF_STATUS = 5'h18;
  localparam logic [4:0] OFF_ID     = 5'h1C;

  localparam logic [IDX_W-1:0] IDX_STATUS = OFF_STATUS[4:2];
  localparam logic [IDX_W-1:0] IDX_ID     = OFF_ID[4:2];

  localparam logic [DATA_W-1:0] DEFAULT_ID = 32'h4150_4231;

  // Request captured in the setup phase and held through the access phase.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_regfile.sv
// Six RW registers, the STATUS write/error counters and the read mux.
module apb_regfile
  import apb_regs_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE = DEFAULT_ID
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              err_pulse,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs [NUM_RW_REGS];
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  err_cnt;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < NUM_RW_REGS; i++) regs[i] <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (wr_en && (wr_idx < IDX_W'(NUM_RW_REGS))) begin
        regs[wr_idx] <= wr_data;
        wr_cnt       <= wr_cnt + CNT_W'(1);
      end
      // Error count saturates; write count wraps.
      if (err_pulse && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_idx == IDX_STATUS)     rd_data = {err_cnt, wr_cnt};
    else if (rd_idx == IDX_ID)    rd_data = ID_VALUE;
    else if (rd_idx < IDX_W'(NUM_RW_REGS)) rd_data = regs[rd_idx];
  end

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer: setup/access FSM, programmable wait states and address decode.
module apb_slave_regs
  import apb_regs_pkg::*;
#(
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [DATA_W-1:0] ID_VALUE    = DEFAULT_ID
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  state_t            state, state_n;
  logic [WCNT_W-1:0] wcnt, wcnt_n;
  apb_req_t          req_q, req_n;

  logic              req_err;
  logic              complete;
  logic              wr_en;
  logic              err_pulse;
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state <= IDLE;
      wcnt  <= '0;
      req_q <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      req_q <= req_n;
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    req_n   = req_q;
    unique case (state)
      IDLE: begin
        if (psel && !penable) begin
          req_n   = '{write: pwrite, addr: paddr, wdata: pwdata};
          wcnt_n  = WCNT_W'(WAIT_CYCLES);
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel)              state_n = IDLE;
        else if (wcnt != '0)    wcnt_n  = wcnt - WCNT_W'(1);
        else if (penable)       state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Decode works only on the latched request; live paddr/pwdata are ignored in ACCESS.
  always_comb begin
    req_err = (req_q.addr[1:0] != 2'b00) ||
              (req_q.addr[ADDR_W-1:5] != BASE_ADDR[ADDR_W-1:5]) ||
              (req_q.write && ((req_q.addr[4:0] == OFF_STATUS) || (req_q.addr[4:0] == OFF_ID)));
  end

  assign pready    = (state == ACCESS) && (wcnt == '0);
  assign pslverr   = pready && req_err;
  assign prdata    = (pready && !req_err && !req_q.write) ? rd_data : '0;
  assign complete  = pready && psel && penable;
  assign wr_en     = complete && req_q.write && !req_err;
  assign err_pulse = complete && req_err;

  apb_regfile #(
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .hclk      (hclk),
    .hreset    (hreset),
    .wr_en     (wr_en),
    .wr_idx    (req_q.addr[4:2]),
    .wr_data   (req_q.wdata),
    .err_pulse (err_pulse),
    .rd_idx    (req_q.addr[4:2]),
    .rd_data   (rd_data)
  );

endmodule
